// File: rtl/mem_access_ctrl_pkg.sv
// Shared bus widths, memory-op codes and sequencer state encoding for the MEM-stage
// load/store sequencer.
package mem_access_ctrl_pkg;

  localparam int ADDR_BUS_W     = 32;
  localparam int DATA_BUS_W     = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int SEL_W          = DATA_BUS_W / 8;

  typedef logic [DATA_BUS_W-1:0]     data_bus_t;
  typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_load(mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Little-endian lane steering: byte enables, store-data replication, load extraction
// with sign/zero extension, and natural-alignment check. Purely combinational.
module mem_align
  import mem_access_ctrl_pkg::*;
(
  input  mem_op_e         op_i,
  input  logic [1:0]      lane_i,
  input  data_bus_t       wdata_i,
  input  data_bus_t       rdata_i,
  output logic [SEL_W-1:0] sel_o,
  output data_bus_t       wdata_o,
  output data_bus_t       rdata_o,
  output logic            misaligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_v = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    sel_o        = '0;
    wdata_o      = '0;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    case (op_i)
      MEM_LB:  begin sel_o = 4'b0001 << lane_i; rdata_o = {{24{byte_v[7]}}, byte_v}; end
      MEM_LBU: begin sel_o = 4'b0001 << lane_i; rdata_o = {24'd0, byte_v}; end
      MEM_SB:  begin sel_o = 4'b0001 << lane_i; wdata_o = {4{wdata_i[7:0]}}; end
      MEM_LH: begin
        sel_o        = lane_i[1] ? 4'b1100 : 4'b0011;
        rdata_o      = {{16{half_v[15]}}, half_v};
        misaligned_o = lane_i[0];
      end
      MEM_LHU: begin
        sel_o        = lane_i[1] ? 4'b1100 : 4'b0011;
        rdata_o      = {16'd0, half_v};
        misaligned_o = lane_i[0];
      end
      MEM_SH: begin
        sel_o        = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = lane_i[0];
      end
      MEM_LW: begin sel_o = 4'b1111; rdata_o = rdata_i; misaligned_o = |lane_i; end
      MEM_SW: begin sel_o = 4'b1111; wdata_o = wdata_i; misaligned_o = |lane_i; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one valid/ready bus transaction per memory op,
// stalls the pipeline until it completes, and presents the aligned writeback triple.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_BUS_W,
  parameter int DATA_W     = DATA_BUS_W,
  parameter int REG_ADDR_W = REG_ADDR_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  flush,
  input  logic [3:0]            mem_op_in,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic [DATA_W-1:0]     result_in,
  input  logic                  write_reg_en_in,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [3:0]            bus_sel,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_err,
  output logic                  stall_req,
  output logic [DATA_W-1:0]     result_out,
  output logic                  write_reg_en_out,
  output logic [REG_ADDR_W-1:0] write_reg_addr_out,
  output logic                  adel,
  output logic                  ades,
  output logic                  bus_err_out
);

  state_e                state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [3:0]            bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
  mem_op_e               op_q, op_d;
  logic [1:0]            lane_q, lane_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic                  flushed_q, flushed_d;
  logic [DATA_W-1:0]     ldata_q, ldata_d;
  logic                  err_q, err_d;

  mem_op_e     op_in;
  mem_op_e     al_op;
  logic [1:0]  al_lane;
  logic [3:0]  al_sel;
  logic [DATA_W-1:0] al_wdata, al_rdata;
  logic        al_misaligned;

  assign op_in = mem_op_e'(mem_op_in);

  // In IDLE the aligner sees the incoming op; afterwards it extracts load data from the bus.
  assign al_op   = (state_q == ST_IDLE) ? op_in : op_q;
  assign al_lane = (state_q == ST_IDLE) ? addr_in[1:0] : lane_q;

  mem_align u_align (
    .op_i         (al_op),
    .lane_i       (al_lane),
    .wdata_i      (store_data_in),
    .rdata_i      (bus_rdata),
    .sel_o        (al_sel),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    op_d        = op_q;
    lane_d      = lane_q;
    wen_d       = wen_q;
    waddr_d     = waddr_q;
    flushed_d   = flushed_q;
    ldata_d     = ldata_q;
    err_d       = err_q;

    stall_req          = 1'b0;
    result_out         = '0;
    write_reg_en_out   = 1'b0;
    write_reg_addr_out = '0;
    adel               = 1'b0;
    ades               = 1'b0;
    bus_err_out        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in && !flush) begin
          if (is_load(op_in) || is_store(op_in)) begin
            if (al_misaligned) begin
              adel = is_load(op_in);
              ades = is_store(op_in);
            end else begin
              stall_req   = 1'b1;
              state_d     = ST_ACCESS;
              bus_req_d   = 1'b1;
              bus_we_d    = is_store(op_in);
              bus_addr_d  = {addr_in[ADDR_W-1:2], 2'b00};
              bus_sel_d   = al_sel;
              bus_wdata_d = al_wdata;
              op_d        = op_in;
              lane_d      = addr_in[1:0];
              wen_d       = write_reg_en_in;
              waddr_d     = write_reg_addr_in;
              flushed_d   = 1'b0;
              ldata_d     = '0;
              err_d       = 1'b0;
            end
          end else begin
            result_out         = result_in;
            write_reg_en_out   = write_reg_en_in;
            write_reg_addr_out = write_reg_addr_in;
          end
        end
      end
      ST_ACCESS: begin
        stall_req = 1'b1;
        // A flush cannot abort a started bus transaction; it only cancels the writeback.
        if (flush) flushed_d = 1'b1;
        if (bus_req_q && bus_ready) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          ldata_d   = al_rdata;
          err_d     = bus_err;
        end
      end
      ST_DONE: begin
        state_d            = ST_IDLE;
        result_out         = ldata_q;
        write_reg_en_out   = wen_q && is_load(op_q) && !flushed_q && !err_q && !flush;
        write_reg_addr_out = waddr_q;
        bus_err_out        = err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      op_q        <= MEM_NONE;
      lane_q      <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      flushed_q   <= 1'b0;
      ldata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      flushed_q   <= flushed_d;
      ldata_q     <= ldata_d;
      err_q       <= err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, misalignment, flush, bus error,
// reset mid-transaction and non-memory pass-through.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        flush;
  logic [3:0]  mem_op_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [31:0] result_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        stall_req;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
  logic        adel;
  logic        ades;
  logic        bus_err_out;

  int total = 0;
  int bad   = 0;

  int          stalls;
  int          reqs;
  logic [3:0]  seen_sel;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;
  logic        seen_we;

  mem_access_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .flush              (flush),
    .mem_op_in          (mem_op_in),
    .addr_in            (addr_in),
    .store_data_in      (store_data_in),
    .result_in          (result_in),
    .write_reg_en_in    (write_reg_en_in),
    .write_reg_addr_in  (write_reg_addr_in),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_sel            (bus_sel),
    .bus_wdata          (bus_wdata),
    .bus_ready          (bus_ready),
    .bus_rdata          (bus_rdata),
    .bus_err            (bus_err),
    .stall_req          (stall_req),
    .result_out         (result_out),
    .write_reg_en_out   (write_reg_en_out),
    .write_reg_addr_out (write_reg_addr_out),
    .adel               (adel),
    .ades               (ades),
    .bus_err_out        (bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one memory op at a negedge and runs it until stall_req drops (the DONE cycle).
  // Bus ready is raised after `waits` wait cycles in ACCESS; inputs are scrambled after issue.
  task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic wen, input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata, input logic err, input logic flush_acc);
    int n;
    @(negedge clk);
    valid_in = 1'b1; mem_op_in = op; addr_in = addr; store_data_in = sdata;
    write_reg_en_in = wen; write_reg_addr_in = rd; flush = 1'b0; bus_ready = 1'b0;
    #1;
    stalls = 0; reqs = 0; n = 0;
    while (stall_req === 1'b1 && n < 40) begin
      stalls++;
      @(negedge clk);
      n++;
      valid_in = 1'b0; mem_op_in = 4'hF; addr_in = 32'hFFFF_FFFF; store_data_in = 32'h5555_5555;
      write_reg_en_in = 1'b0; write_reg_addr_in = 5'd31;
      flush     = flush_acc && (n == 1);
      bus_ready = (n == waits + 1);
      bus_rdata = rdata;
      bus_err   = err;
      #1;
      if (bus_req === 1'b1) reqs++;
      if (n == 1) begin
        seen_sel = bus_sel; seen_addr = bus_addr; seen_wdata = bus_wdata; seen_we = bus_we;
      end
    end
    flush = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; mem_op_in = 4'd0; addr_in = '0;
    store_data_in = '0; result_in = '0; write_reg_en_in = 1'b0; write_reg_addr_in = '0;
    bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    stalls = 0; reqs = 0; seen_sel = '0; seen_addr = '0; seen_wdata = '0; seen_we = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_sel", {28'd0, bus_sel}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wen", {31'd0, write_reg_en_out}, 32'd0);
    rst = 1'b0;

    // LW 0x1000, two wait cycles
    mem_txn(MEM_LW, 32'h0000_1000, 32'h0, 1'b1, 5'd7, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("lw_stalls", stalls, 4);
    check("lw_req_held", reqs, 3);
    check("lw_sel", {28'd0, seen_sel}, 32'h0000_000F);
    check("lw_addr", seen_addr, 32'h0000_1000);
    check("lw_we", {31'd0, seen_we}, 32'd0);
    check("lw_result", result_out, 32'hDEAD_BEEF);
    check("lw_wen", {31'd0, write_reg_en_out}, 32'd1);
    check("lw_rd", {27'd0, write_reg_addr_out}, 32'd7);
    check("lw_done_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk); #1;
    check("lw_after_wen", {31'd0, write_reg_en_out}, 32'd0);
    check("lw_after_stall", {31'd0, stall_req}, 32'd0);

    // LB / LBU at top byte lane, sign vs zero extension
    mem_txn(MEM_LB, 32'h0000_1003, 32'h0, 1'b1, 5'd4, 0, 32'h8000_0000, 1'b0, 1'b0);
    check("lb_stalls", stalls, 2);
    check("lb_sel", {28'd0, seen_sel}, 32'h0000_0008);
    check("lb_result", result_out, 32'hFFFF_FF80);
    mem_txn(MEM_LBU, 32'h0000_1003, 32'h0, 1'b1, 5'd4, 0, 32'h8000_0000, 1'b0, 1'b0);
    check("lbu_result", result_out, 32'h0000_0080);

    // Halfword loads
    mem_txn(MEM_LH, 32'h0000_1002, 32'h0, 1'b1, 5'd5, 1, 32'h8001_1234, 1'b0, 1'b0);
    check("lh_sel", {28'd0, seen_sel}, 32'h0000_000C);
    check("lh_result", result_out, 32'hFFFF_8001);
    mem_txn(MEM_LHU, 32'h0000_1000, 32'h0, 1'b1, 5'd5, 0, 32'h1234_F00F, 1'b0, 1'b0);
    check("lhu_sel", {28'd0, seen_sel}, 32'h0000_0003);
    check("lhu_result", result_out, 32'h0000_F00F);

    // SH 0x2002
    mem_txn(MEM_SH, 32'h0000_2002, 32'h0000_ABCD, 1'b1, 5'd9, 0, 32'h0, 1'b0, 1'b0);
    check("sh_we", {31'd0, seen_we}, 32'd1);
    check("sh_sel", {28'd0, seen_sel}, 32'h0000_000C);
    check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_addr", seen_addr, 32'h0000_2000);
    check("sh_wen", {31'd0, write_reg_en_out}, 32'd0);

    // SB lane 1
    mem_txn(MEM_SB, 32'h0000_2001, 32'h0000_0077, 1'b0, 5'd0, 0, 32'h0, 1'b0, 1'b0);
    check("sb_sel", {28'd0, seen_sel}, 32'h0000_0002);
    check("sb_wdata", seen_wdata, 32'h7777_7777);

    // Misaligned LW: address error, no request, no stall
    @(negedge clk);
    valid_in = 1'b1; mem_op_in = MEM_LW; addr_in = 32'h0000_1001; write_reg_en_in = 1'b1;
    write_reg_addr_in = 5'd2;
    #1;
    check("mis_lw_adel", {31'd0, adel}, 32'd1);
    check("mis_lw_ades", {31'd0, ades}, 32'd0);
    check("mis_lw_stall", {31'd0, stall_req}, 32'd0);
    check("mis_lw_wen", {31'd0, write_reg_en_out}, 32'd0);
    @(negedge clk);
    mem_op_in = MEM_SW; addr_in = 32'h0000_2002;
    #1;
    check("mis_lw_no_req", {31'd0, bus_req}, 32'd0);
    check("mis_sw_ades", {31'd0, ades}, 32'd1);
    check("mis_sw_adel", {31'd0, adel}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("mis_sw_no_req", {31'd0, bus_req}, 32'd0);

    // Flush during ACCESS: request completes, writeback suppressed
    mem_txn(MEM_LW, 32'h0000_3000, 32'h0, 1'b1, 5'd8, 2, 32'h1111_2222, 1'b0, 1'b1);
    check("flush_req_held", reqs, 3);
    check("flush_stalls", stalls, 4);
    check("flush_wen", {31'd0, write_reg_en_out}, 32'd0);

    // Bus error at handshake
    mem_txn(MEM_LW, 32'h0000_3004, 32'h0, 1'b1, 5'd8, 0, 32'h3333_4444, 1'b1, 1'b0);
    check("err_out", {31'd0, bus_err_out}, 32'd1);
    check("err_wen", {31'd0, write_reg_en_out}, 32'd0);

    // Non-memory op pass-through, then !valid_in
    @(negedge clk);
    valid_in = 1'b1; mem_op_in = MEM_NONE; result_in = 32'h0000_0005;
    write_reg_en_in = 1'b1; write_reg_addr_in = 5'd3;
    #1;
    check("add_result", result_out, 32'h0000_0005);
    check("add_wen", {31'd0, write_reg_en_out}, 32'd1);
    check("add_rd", {27'd0, write_reg_addr_out}, 32'd3);
    check("add_stall", {31'd0, stall_req}, 32'd0);
    valid_in = 1'b0;
    #1;
    check("invalid_result", result_out, 32'd0);
    check("invalid_wen", {31'd0, write_reg_en_out}, 32'd0);

    // Flush in IDLE blocks issue
    @(negedge clk);
    valid_in = 1'b1; flush = 1'b1; mem_op_in = MEM_LW; addr_in = 32'h0000_1000;
    #1;
    check("idle_flush_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_no_req", {31'd0, bus_req}, 32'd0);

    // Reset while in ACCESS drops bus_req without a clock edge
    @(negedge clk);
    valid_in = 1'b1; mem_op_in = MEM_LW; addr_in = 32'h0000_4000; bus_ready = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("rst_acc_req_before", {31'd0, bus_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_acc_req_after", {31'd0, bus_req}, 32'd0);
    check("rst_acc_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_acc_idle_req", {31'd0, bus_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
